// File: rtl/debounce_multi_switch.sv
// Per-channel switch debouncer with rise/fall pulses; output lags a stable pin by DEBOUNCE_LIMIT+2 clocks.
// No backpressure: pulses are one-shot. Define DEBOUNCE_HOLD_DETECT_EN to add long-press detection on o_Hold.
module debounce_multi_switch #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 25000000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switches,
  output logic [NUM_SWITCHES-1:0] o_Switches,
  output logic [NUM_SWITCHES-1:0] o_Rise,
  output logic [NUM_SWITCHES-1:0] o_Fall,
  output logic [NUM_SWITCHES-1:0] o_Hold
);

  localparam int DB_W = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

  if (NUM_SWITCHES < 1 || DEBOUNCE_LIMIT < 1 || HOLD_LIMIT < 1) begin : g_bad_param
    $error("debounce_multi_switch: all parameters must be at least 1");
  end

  logic [NUM_SWITCHES-1:0] r_sync1;
  logic [NUM_SWITCHES-1:0] r_sync2;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_Switches;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar k = 0; k < NUM_SWITCHES; k++) begin : g_ch
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic            w_diff;
    logic            w_load;

    assign w_diff = r_sync2[k] ^ r_level;
    assign w_load = w_diff && (r_cnt == DB_LAST);

    // Any clock where the synced pin agrees with the output restarts qualification.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= w_load & r_sync2[k];
        r_fall <= w_load & ~r_sync2[k];
        if (w_load) begin
          r_level <= r_sync2[k];
          r_cnt   <= '0;
        end else if (w_diff) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign o_Switches[k] = r_level;
    assign o_Rise[k]     = r_rise;
    assign o_Fall[k]     = r_fall;

`ifdef DEBOUNCE_HOLD_DETECT_EN
    localparam int HOLD_W = $clog2(HOLD_LIMIT) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              r_hold;

    // While the level is high a load can only be a fall, so it clears alongside the drop.
    always_comb begin
      w_hold_cnt_nxt = r_hold_cnt;
      if (!r_level || w_load) begin
        w_hold_cnt_nxt = '0;
      end else if (r_hold_cnt != HOLD_MAX) begin
        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
      end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_hold_cnt <= '0;
        r_hold     <= 1'b0;
      end else begin
        r_hold_cnt <= w_hold_cnt_nxt;
        r_hold     <= (w_hold_cnt_nxt == HOLD_MAX);
      end
    end

    assign o_Hold[k] = r_hold;
`else
    assign o_Hold[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_multi_switch.sv
// Bench for debounce_multi_switch: vector table, corner sequences, then random pins against a sliding-window model.
// Hold expectations follow whether DEBOUNCE_HOLD_DETECT_EN is defined for the build.
module tb_debounce_multi_switch;
  localparam int NS = 4;
  localparam int DB = 4;
  localparam int HL = 10;

  logic          i_Clk      = 1'b0;
  logic          i_Rst_L    = 1'b1;
  logic [NS-1:0] i_Switches = '0;
  logic [NS-1:0] o_Switches;
  logic [NS-1:0] o_Rise;
  logic [NS-1:0] o_Fall;
  logic [NS-1:0] o_Hold;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  debounce_multi_switch #(
    .NUM_SWITCHES  (NS),
    .DEBOUNCE_LIMIT(DB),
    .HOLD_LIMIT    (HL)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Switches(i_Switches),
    .o_Switches(o_Switches),
    .o_Rise    (o_Rise),
    .o_Fall    (o_Fall),
    .o_Hold    (o_Hold)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel flips once the last DB synced samples (pin samples two edges old) all disagree with it.
  logic [NS-1:0] m_hist [DB+2];
  logic [NS-1:0] m_out  = '0;
  logic [NS-1:0] m_rise = '0;
  logic [NS-1:0] m_fall = '0;
  logic [NS-1:0] m_hold = '0;
  int            m_age  [NS];
  bit            m_flip;

  initial begin
    for (int i = 0; i < DB + 2; i++) m_hist[i] = '0;
    for (int k = 0; k < NS; k++) m_age[k] = 0;
    forever begin
      @(posedge i_Clk or negedge i_Rst_L);
      if (!i_Rst_L) begin
        for (int i = 0; i < DB + 2; i++) m_hist[i] = '0;
        for (int k = 0; k < NS; k++) m_age[k] = 0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_hold = '0;
      end else begin
        for (int i = DB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = i_Switches;
        for (int k = 0; k < NS; k++) begin
          m_flip = 1'b1;
          for (int i = 2; i < DB + 2; i++) begin
            if (m_hist[i][k] == m_out[k]) m_flip = 1'b0;
          end
          if (m_flip) begin
            m_out[k]  = ~m_out[k];
            m_rise[k] = m_out[k];
            m_fall[k] = ~m_out[k];
            m_age[k]  = 0;
          end else begin
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (m_out[k] && m_age[k] < HL) m_age[k]++;
          end
`ifdef DEBOUNCE_HOLD_DETECT_EN
          m_hold[k] = m_out[k] && (m_age[k] >= HL);
`else
          m_hold[k] = 1'b0;
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_Clk);
      #1;
      if (chk_en) begin
        chk("mdl_sw",   o_Switches, m_out);
        chk("mdl_rise", o_Rise,     m_rise);
        chk("mdl_fall", o_Fall,     m_fall);
        chk("mdl_hold", o_Hold,     m_hold);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [NS-1:0] pins;
    int            adv;
    logic [NS-1:0] sw;
    logic [NS-1:0] rise;
    logic [NS-1:0] fall;
  } vec_t;

  vec_t          tbl [12];
  int            n;
  int            dur [NS];
  logic [NS-1:0] lvl;

  initial begin
    tbl[0]  = '{4'b0001, 5, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1101, 5, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1101, 1, 4'b1101, 4'b1100, 4'b0000};
    tbl[5]  = '{4'b1101, 1, 4'b1101, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0001, 5, 4'b1101, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b1100};
    tbl[8]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b0001};
    tbl[10] = '{4'b0100, 3, 4'b0000, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0000, 8, 4'b0000, 4'b0000, 4'b0000};

    #1 i_Rst_L = 1'b0;
    #1;
    chk("reset_sw",   o_Switches, '0);
    chk("reset_rise", o_Rise,     '0);
    chk("reset_fall", o_Fall,     '0);
    chk("reset_hold", o_Hold,     '0);
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    chk_en  = 1'b1;

    for (int i = 0; i < 12; i++) begin
      i_Switches = tbl[i].pins;
      repeat (tbl[i].adv) @(negedge i_Clk);
      chk($sformatf("tbl%0d_sw", i),   o_Switches, tbl[i].sw);
      chk($sformatf("tbl%0d_rise", i), o_Rise,     tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), o_Fall,     tbl[i].fall);
    end

    // Channel 1 toggling every 3 clocks never qualifies; the final steady high does.
    for (int t = 0; t < 4; t++) begin
      i_Switches = (t % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (3) begin
        @(negedge i_Clk);
        chk("toggle_sw", o_Switches, 4'b0000);
      end
    end
    i_Switches = 4'b0010;
    repeat (5) begin
      @(negedge i_Clk);
      chk("toggle_final_quiet", o_Switches, 4'b0000);
    end
    @(negedge i_Clk);
    chk("toggle_final_rise", o_Rise,     4'b0010);
    chk("toggle_final_sw",   o_Switches, 4'b0010);
    i_Switches = 4'b0000;
    repeat (8) @(negedge i_Clk);

    // Reset mid-qualification of channel 0 while channel 3 is already high.
    i_Switches = 4'b1000;
    repeat (7) @(negedge i_Clk);
    chk("pre_rst_sw", o_Switches, 4'b1000);
    i_Switches = 4'b1001;
    repeat (2) @(negedge i_Clk);
    #2 i_Rst_L = 1'b0;
    #1;
    chk("rst_async_sw",   o_Switches, '0);
    chk("rst_async_rise", o_Rise,     '0);
    chk("rst_async_fall", o_Fall,     '0);
    chk("rst_async_hold", o_Hold,     '0);
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (5) begin
      @(negedge i_Clk);
      chk("rst_requal_quiet", o_Rise, 4'b0000);
    end
    @(negedge i_Clk);
    chk("rst_requal_rise", o_Rise, 4'b1001);
    i_Switches = 4'b0000;
    repeat (8) @(negedge i_Clk);

    // Long press on channel 0.
    i_Switches = 4'b0001;
    n = 0;
    while (!o_Switches[0] && n < 20) begin
      @(negedge i_Clk);
      n++;
    end
    chk_i("hold_sw_latency", n, DB + 2);
`ifdef DEBOUNCE_HOLD_DETECT_EN
    n = 0;
    while (!o_Hold[0] && n < 30) begin
      @(negedge i_Clk);
      n++;
    end
    chk_i("hold_latency", n, HL);
`else
    repeat (30) begin
      @(negedge i_Clk);
      chk("hold_disabled", o_Hold, 4'b0000);
    end
`endif
    i_Switches = 4'b0000;
    n = 0;
    while (!o_Fall[0] && n < 20) begin
`ifdef DEBOUNCE_HOLD_DETECT_EN
      chk("hold_before_fall", o_Hold, 4'b0001);
`else
      chk("hold_before_fall", o_Hold, 4'b0000);
`endif
      @(negedge i_Clk);
      n++;
    end
    chk_i("hold_fall_latency", n, DB + 2);
    chk("hold_clear_with_fall", o_Hold, 4'b0000);
    repeat (4) @(negedge i_Clk);

    // Random bouncy pins with occasional resets, all judged by the model.
    for (int k = 0; k < NS; k++) dur[k] = 0;
    lvl = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NS; k++) begin
        if (dur[k] == 0) begin
          lvl[k] = 1'($urandom_range(0, 1));
          dur[k] = $urandom_range(1, 20);
        end
        dur[k]--;
      end
      i_Switches = lvl;
      i_Rst_L    = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      @(negedge i_Clk);
    end
    i_Rst_L = 1'b1;
    repeat (4) @(negedge i_Clk);
    #2 chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
